// File: rtl/one_wire_master.sv
// Parametrised 1-Wire bus master: reset/presence, bit-slot read/write, bus-short
// detection, strong-pullup request after writes and Dallas CRC-8 on read data.
module one_wire_master #(
    parameter int CLK_MHZ   = 25,
    parameter int MAX_BITS  = 64,
    parameter int T_RSTL_US = 480,
    parameter int T_RSTH_US = 480,
    parameter int T_MSP_US  = 70,
    parameter int T_SLOT_US = 70,
    parameter int T_LOW0_US = 60,
    parameter int T_LOW1_US = 6,
    parameter int T_LOWR_US = 2,
    parameter int T_MSR_US  = 12,
    parameter int T_REC_US  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_bus_reset,
    input  logic                          cmd_write,
    input  logic                          cmd_read,
    input  logic [$clog2(MAX_BITS+1)-1:0] nbits,
    input  logic [MAX_BITS-1:0]           tx_data,
    input  logic                          spu_req,
    output logic [MAX_BITS-1:0]           rx_data,
    output logic                          wire_oe,
    input  logic                          wire_in,
    output logic                          spu,
    output logic                          busy,
    output logic                          done,
    output logic                          presence,
    output logic                          short_det,
    output logic [7:0]                    crc8,
    output logic                          crc_ok
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int NBW    = $clog2(MAX_BITS + 1);
    localparam int BW     = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int C_RSTL = T_RSTL_US * CLK_MHZ;
    localparam int C_RSTH = T_RSTH_US * CLK_MHZ;
    localparam int C_MSP  = T_MSP_US * CLK_MHZ;
    localparam int C_SLOT = T_SLOT_US * CLK_MHZ;
    localparam int C_LOW0 = T_LOW0_US * CLK_MHZ;
    localparam int C_LOW1 = T_LOW1_US * CLK_MHZ;
    localparam int C_LOWR = T_LOWR_US * CLK_MHZ;
    localparam int C_MSR  = T_MSR_US * CLK_MHZ;
    localparam int C_REC  = T_REC_US * CLK_MHZ;
    localparam int C_MAX  = max2(max2(C_RSTL, C_RSTH), max2(C_SLOT, C_REC));
    localparam int CW     = $clog2(C_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, RST_LOW, RST_WAIT, SLOT_LOW, SLOT_HIGH, SLOT_REC, FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [NBW-1:0]      nbits_q, nbits_d;
    logic [MAX_BITS-1:0] tx_q, tx_d;
    logic [MAX_BITS-1:0] rx_q, rx_d;
    logic                rd_q, rd_d;
    logic                spu_req_q, spu_req_d;
    logic [1:0]          sync_q;
    logic                oe_q, oe_d;
    logic                spu_q, spu_d;
    logic                presence_q, presence_d;
    logic                short_q, short_d;
    logic [7:0]          crc_q, crc_d;
    logic                crc_ok_q, crc_ok_d;
    logic                accept;
    logic                line;
    logic [CW-1:0]       low_n, high_n;
    logic [7:0]          crc_next;

    assign line = sync_q[1];

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        nbits_d    = nbits_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rd_d       = rd_q;
        spu_req_d  = spu_req_q;
        spu_d      = spu_q;
        presence_d = presence_q;
        short_d    = short_q;
        crc_d      = crc_q;
        crc_ok_d   = crc_ok_q;
        accept     = 1'b0;
        low_n      = rd_q ? CW'(C_LOWR) : (tx_q[bit_q] ? CW'(C_LOW1) : CW'(C_LOW0));
        high_n     = CW'(C_SLOT) - low_n;
        crc_next   = {1'b0, crc_q[7:1]} ^ ((crc_q[0] ^ line) ? 8'h8C : 8'h00);

        case (state_q)
            IDLE: begin
                if (cmd_bus_reset || cmd_write || cmd_read) begin
                    accept    = 1'b1;
                    spu_d     = 1'b0;
                    bit_d     = '0;
                    nbits_d   = (nbits > NBW'(MAX_BITS)) ? NBW'(MAX_BITS) : nbits;
                    rd_d      = !cmd_bus_reset && !cmd_write;
                    spu_req_d = !cmd_bus_reset && cmd_write && spu_req;
                    tx_d      = tx_data;
                    if (cmd_bus_reset) begin
                        presence_d = 1'b0;
                        short_d    = !line;
                        state_d    = line ? RST_LOW : FINISH;
                    end else begin
                        if (!cmd_write) begin
                            rx_d     = '0;
                            crc_d    = '0;
                            crc_ok_d = 1'b0;
                        end
                        state_d = (nbits_d == '0) ? FINISH : SLOT_LOW;
                    end
                end
            end
            RST_LOW: if (cnt_q == CW'(C_RSTL - 1)) state_d = RST_WAIT;
            RST_WAIT: begin
                if (cnt_q == CW'(C_MSP)) presence_d = !line;
                if (cnt_q == CW'(C_RSTH - 1)) state_d = FINISH;
            end
            SLOT_LOW: if (cnt_q == low_n - CW'(1)) state_d = SLOT_HIGH;
            SLOT_HIGH: begin
                // Sample point is counted from the falling edge, so subtract the read low time.
                if (rd_q && cnt_q == CW'(C_MSR - C_LOWR)) begin
                    rx_d[bit_q] = line;
                    crc_d       = crc_next;
                end
                if (cnt_q == high_n - CW'(1)) state_d = SLOT_REC;
            end
            SLOT_REC: begin
                if (cnt_q == CW'(C_REC - 1)) begin
                    if (NBW'(bit_q) == nbits_q - NBW'(1)) begin
                        state_d = FINISH;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        state_d = SLOT_LOW;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (rd_q && nbits_q != '0) crc_ok_d = (crc_q == 8'h00);
                if (spu_req_q) spu_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CW'(1);
        oe_d  = (state_d == RST_LOW) || (state_d == SLOT_LOW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            nbits_q    <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rd_q       <= 1'b0;
            spu_req_q  <= 1'b0;
            sync_q     <= 2'b11;
            oe_q       <= 1'b0;
            spu_q      <= 1'b0;
            presence_q <= 1'b0;
            short_q    <= 1'b0;
            crc_q      <= '0;
            crc_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            nbits_q    <= nbits_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rd_q       <= rd_d;
            spu_req_q  <= spu_req_d;
            sync_q     <= {sync_q[0], wire_in};
            oe_q       <= oe_d;
            spu_q      <= spu_d;
            presence_q <= presence_d;
            short_q    <= short_d;
            crc_q      <= crc_d;
            crc_ok_q   <= crc_ok_d;
        end
    end

    assign wire_oe   = oe_q;
    assign spu       = spu_q;
    assign busy      = (state_q != IDLE) || accept;
    assign done      = (state_q == FINISH);
    assign presence  = presence_q;
    assign short_det = short_q;
    assign rx_data   = rx_q;
    assign crc8      = crc_q;
    assign crc_ok    = crc_ok_q;
endmodule

// File: tb/tb_one_wire_master.sv
// Directed bench for one_wire_master with a behavioural slave on the line,
// run at a 2 MHz clock so the 64-bit transfers stay short.
`timescale 1ns/1ps
module tb_one_wire_master;
    localparam int CLK_MHZ  = 2;
    localparam int MAX_BITS = 64;
    localparam int NBW      = $clog2(MAX_BITS + 1);
    localparam int C_RSTL   = 480 * CLK_MHZ;
    localparam int C_RSTH   = 480 * CLK_MHZ;
    localparam int C_SLOT   = 70 * CLK_MHZ;
    localparam int C_LOW0   = 60 * CLK_MHZ;
    localparam int C_LOW1   = 6 * CLK_MHZ;
    localparam int C_REC    = 2 * CLK_MHZ;
    localparam int C_BIT    = C_SLOT + C_REC;
    localparam logic [63:0] ROM_CODE = 64'hA200_0000_01B8_1C02;

    logic                clk = 1'b0;
    logic                reset;
    logic                cmd_bus_reset, cmd_write, cmd_read;
    logic [NBW-1:0]      nbits;
    logic [MAX_BITS-1:0] tx_data;
    logic                spu_req;
    logic [MAX_BITS-1:0] rx_data;
    logic                wire_oe, wire_in;
    logic                spu, busy, done, presence, short_det, crc_ok;
    logic [7:0]          crc8;

    logic                slave_pull = 1'b0;
    logic                stuck_low;
    logic                slave_read_en, slave_presence_en;
    logic [63:0]         slave_bits;
    int                  slave_idx;
    int                  cyc = 0;
    int                  errors = 0;
    int                  checks = 0;

    one_wire_master #(.CLK_MHZ(CLK_MHZ), .MAX_BITS(MAX_BITS)) dut (
        .clk(clk), .reset(reset),
        .cmd_bus_reset(cmd_bus_reset), .cmd_write(cmd_write), .cmd_read(cmd_read),
        .nbits(nbits), .tx_data(tx_data), .spu_req(spu_req), .rx_data(rx_data),
        .wire_oe(wire_oe), .wire_in(wire_in), .spu(spu), .busy(busy), .done(done),
        .presence(presence), .short_det(short_det), .crc8(crc8), .crc_ok(crc_ok)
    );

    assign wire_in = ~(wire_oe | slave_pull | stuck_low);

    always #250 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: answers a bus reset with a presence pulse, or returns slave_bits on read slots.
    initial begin
        forever begin
            @(posedge wire_oe);
            if (slave_read_en) begin
                if (slave_idx < 64 && slave_bits[slave_idx] == 1'b0) begin
                    slave_pull = 1'b1;
                    repeat (30 * CLK_MHZ) @(posedge clk);
                    slave_pull = 1'b0;
                end
                slave_idx++;
            end else if (slave_presence_en) begin
                @(negedge wire_oe);
                repeat (30 * CLK_MHZ) @(posedge clk);
                slave_pull = 1'b1;
                repeat (120 * CLK_MHZ) @(posedge clk);
                slave_pull = 1'b0;
            end
        end
    end

    function automatic logic [7:0] crc_model(input logic [63:0] d, input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ 8'h8C;
        end
        return c;
    endfunction

    task automatic measure_level(input logic lvl, input int limit, output int n);
        n = 0;
        while (wire_oe === lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done(input int limit, output int waited);
        waited = 0;
        while (done !== 1'b1 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({wire_oe, spu, busy, done, presence, short_det, crc_ok} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b want 0000000",
                     {wire_oe, spu, busy, done, presence, short_det, crc_ok});
        end
        checks++;
        if (rx_data !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_rx got %h want 0", rx_data);
        end
        checks++;
        if (crc8 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_crc got %h want 00", crc8);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bus_reset();
        int n, t0, w;
        slave_presence_en = 1'b1;
        @(negedge clk);
        cmd_bus_reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_accept_busy got %b want 1", busy);
        end
        @(negedge clk);
        cmd_bus_reset = 1'b0;
        t0 = cyc;
        measure_level(1'b1, C_RSTL + 10, n);
        checks++;
        if (n !== C_RSTL) begin
            errors++;
            $display("[TB] FAIL rst_low_len got %0d want %0d", n, C_RSTL);
        end
        wait_done(C_RSTH + 10, w);
        checks++;
        if (done !== 1'b1 || cyc - t0 !== C_RSTL + C_RSTH) begin
            errors++;
            $display("[TB] FAIL rst_done_time got done=%b after %0d want %0d", done, cyc - t0, C_RSTL + C_RSTH);
        end
        checks++;
        if (presence !== 1'b1 || short_det !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_presence got p=%b s=%b want p=1 s=0", presence, short_det);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_busy_drop got busy=%b done=%b want 0 0", busy, done);
        end
        slave_presence_en = 1'b0;
    endtask

    task automatic test_short();
        int  n;
        logic seen_oe;
        stuck_low = 1'b1;
        repeat (4) @(negedge clk);
        cmd_bus_reset = 1'b1;
        @(negedge clk);
        cmd_bus_reset = 1'b0;
        seen_oe = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 3) begin
            if (wire_oe !== 1'b0) seen_oe = 1'b1;
            @(negedge clk);
            n++;
        end
        if (wire_oe !== 1'b0) seen_oe = 1'b1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL short_done got %b want 1 within 3 cycles", done);
        end
        checks++;
        if (short_det !== 1'b1 || presence !== 1'b0) begin
            errors++;
            $display("[TB] FAIL short_flags got s=%b p=%b want s=1 p=0", short_det, presence);
        end
        checks++;
        if (seen_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL short_oe got %b want 0", seen_oe);
        end
        stuck_low = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        int n, w;
        int exp_low [8] = '{C_LOW1, C_LOW0, C_LOW1, C_LOW0, C_LOW0, C_LOW1, C_LOW0, C_LOW1};
        tx_data = 64'hA5;
        nbits   = NBW'(8);
        spu_req = 1'b1;
        @(negedge clk);
        cmd_write = 1'b1;
        @(negedge clk);
        cmd_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            measure_level(1'b1, C_LOW0 + 10, n);
            checks++;
            if (n !== exp_low[i]) begin
                errors++;
                $display("[TB] FAIL write_low[%0d] got %0d want %0d", i, n, exp_low[i]);
            end
            if (i < 7) begin
                measure_level(1'b0, C_BIT + 10, n);
                checks++;
                if (n !== C_BIT - exp_low[i]) begin
                    errors++;
                    $display("[TB] FAIL write_gap[%0d] got %0d want %0d", i, n, C_BIT - exp_low[i]);
                end
            end
        end
        wait_done(C_BIT + 10, w);
        checks++;
        if (done !== 1'b1 || spu !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_done got done=%b spu=%b want 1 0", done, spu);
        end
        @(negedge clk);
        checks++;
        if (spu !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_spu got spu=%b busy=%b want 1 0", spu, busy);
        end
        spu_req = 1'b0;
    endtask

    task automatic test_read(input logic [63:0] pattern, input logic exp_ok);
        int w;
        logic [7:0] exp_crc;
        exp_crc       = crc_model(pattern, 64);
        slave_bits    = pattern;
        slave_idx     = 0;
        slave_read_en = 1'b1;
        nbits         = NBW'(64);
        @(negedge clk);
        cmd_read = 1'b1;
        @(negedge clk);
        cmd_read = 1'b0;
        checks++;
        if (spu !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_spu_clear got %b want 0", spu);
        end
        wait_done(64 * C_BIT + 20, w);
        checks++;
        if (done !== 1'b1 || rx_data !== pattern) begin
            errors++;
            $display("[TB] FAIL read_data got done=%b rx=%h want 1 %h", done, rx_data, pattern);
        end
        checks++;
        if (crc8 !== exp_crc) begin
            errors++;
            $display("[TB] FAIL read_crc got %h want %h", crc8, exp_crc);
        end
        @(negedge clk);
        checks++;
        if (crc_ok !== exp_ok) begin
            errors++;
            $display("[TB] FAIL read_crc_ok got %b want %b", crc_ok, exp_ok);
        end
        slave_read_en = 1'b0;
    endtask

    task automatic test_clamp();
        int   rises, n;
        logic prev;
        tx_data = '1;
        nbits   = NBW'(70);
        @(negedge clk);
        cmd_write = 1'b1;
        @(negedge clk);
        cmd_write = 1'b0;
        rises = 0;
        n     = 0;
        prev  = 1'b0;
        while (done !== 1'b1 && n < 70 * C_BIT) begin
            if (wire_oe === 1'b1 && prev === 1'b0) rises++;
            prev = wire_oe;
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1 || rises !== 64) begin
            errors++;
            $display("[TB] FAIL clamp_slots got done=%b slots=%0d want 1 64", done, rises);
        end
        @(negedge clk);
        checks++;
        if (rx_data !== ROM_CODE || crc_ok !== 1'b1 || crc8 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL write_keeps_rx got rx=%h ok=%b crc=%h want %h 1 00", rx_data, crc_ok, crc8, ROM_CODE);
        end
        checks++;
        if (spu !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clamp_spu got %b want 0", spu);
        end
    endtask

    task automatic test_read_zero();
        nbits = '0;
        @(negedge clk);
        cmd_read = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_accept_busy got %b want 1", busy);
        end
        @(negedge clk);
        cmd_read = 1'b0;
        checks++;
        if (done !== 1'b1 || wire_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_done got done=%b oe=%b want 1 0", done, wire_oe);
        end
        checks++;
        if (rx_data !== 64'h0 || crc8 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL zero_clear got rx=%h crc=%h want 0 00", rx_data, crc8);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || crc_ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_after got done=%b busy=%b ok=%b want 0 0 0", done, busy, crc_ok);
        end
    endtask

    task automatic test_abort();
        int   rises, n, w;
        logic prev, bad;
        logic [7:0] exp_crc;
        slave_bits    = 64'hF0F0_1234_5678_9ABC;
        slave_idx     = 0;
        slave_read_en = 1'b1;
        nbits         = NBW'(64);
        @(negedge clk);
        cmd_read = 1'b1;
        @(negedge clk);
        cmd_read = 1'b0;
        rises = 0;
        n     = 0;
        prev  = 1'b0;
        while (rises < 21 && n < 25 * C_BIT) begin
            if (wire_oe === 1'b1 && prev === 1'b0) rises++;
            prev = wire_oe;
            if (rises < 21) begin
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (rises !== 21 || wire_oe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_reach_bit20 got slots=%0d oe=%b want 21 1", rises, wire_oe);
        end
        #100;
        reset = 1'b1;
        #1;
        checks++;
        if ({wire_oe, spu, busy, done, presence, short_det, crc_ok} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL abort_flags got %b want 0000000",
                     {wire_oe, spu, busy, done, presence, short_det, crc_ok});
        end
        checks++;
        if (rx_data !== 64'h0 || crc8 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL abort_data got rx=%h crc=%h want 0 00", rx_data, crc8);
        end
        @(negedge clk);
        reset = 1'b0;
        slave_read_en = 1'b0;
        bad = 1'b0;
        repeat (2 * C_BIT) begin
            @(negedge clk);
            if (done !== 1'b0 || wire_oe !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_quiet got activity=%b want 0", bad);
        end
        exp_crc       = crc_model(64'h3C, 8);
        slave_bits    = 64'h3C;
        slave_idx     = 0;
        slave_read_en = 1'b1;
        nbits         = NBW'(8);
        @(negedge clk);
        cmd_read = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_abort_accept got %b want 1", busy);
        end
        @(negedge clk);
        cmd_read = 1'b0;
        wait_done(8 * C_BIT + 20, w);
        checks++;
        if (done !== 1'b1 || rx_data !== 64'h3C || crc8 !== exp_crc) begin
            errors++;
            $display("[TB] FAIL post_abort_read got done=%b rx=%h crc=%h want 1 3c %h", done, rx_data, crc8, exp_crc);
        end
        @(negedge clk);
        checks++;
        if (crc_ok !== (exp_crc == 8'h00)) begin
            errors++;
            $display("[TB] FAIL post_abort_crc_ok got %b want %b", crc_ok, exp_crc == 8'h00);
        end
        slave_read_en = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        cmd_bus_reset     = 1'b0;
        cmd_write         = 1'b0;
        cmd_read          = 1'b0;
        nbits             = '0;
        tx_data           = '0;
        spu_req           = 1'b0;
        stuck_low         = 1'b0;
        slave_read_en     = 1'b0;
        slave_presence_en = 1'b0;
        slave_bits        = '0;
        slave_idx         = 0;
        test_reset();
        test_bus_reset();
        test_short();
        test_write();
        test_read(ROM_CODE ^ (64'h1 << 17), 1'b0);
        test_read(ROM_CODE, 1'b1);
        test_clamp();
        test_read_zero();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
